// File: rtl/rf_wb_checker_pkg.sv
// rf_wb_checker_pkg: shared types for the register-file writeback checker
package rf_wb_checker_pkg;
    localparam int REG_IDX_W = 5;
    localparam int XLEN_MAX = 64;
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
    typedef struct packed {
        logic [XLEN_MAX-1:0]  flag;
        logic [REG_IDX_W-1:0] rg;
        logic [XLEN_MAX-1:0]  exp;
    } check_entry_t;
endpackage

// File: rtl/rf_shadow.sv
// rf_shadow: 32-entry shadow of the architectural registers with x0 hardwired to zero
module rf_shadow import rf_wb_checker_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [REG_IDX_W-1:0] flag_addr,
    output logic [XLEN-1:0]      flag_data,
    input  logic [REG_IDX_W-1:0] tgt_addr,
    output logic [XLEN-1:0]      tgt_data
);
    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign flag_data = flag_addr == '0 ? '0 : regs[flag_addr];
    assign tgt_data  = tgt_addr == '0 ? '0 : regs[tgt_addr];
endmodule

// File: rtl/rf_wb_checker.sv
// rf_wb_checker: snoops writebacks and runs a flag-gated sequence of register checks under a watchdog
module rf_wb_checker import rf_wb_checker_pkg::*; #(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32,
    localparam int IDX_W         = $clog2(NUM_CHECKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ld_valid,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [XLEN-1:0]      ld_flag,
    input  logic [4:0]           ld_reg,
    input  logic [XLEN-1:0]      ld_exp,
    input  logic [IDX_W:0]       n_checks,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [IDX_W-1:0]     fail_idx,
    output logic [XLEN-1:0]      fail_got,
    output logic [IDX_W:0]       checks_passed
);
    state_t state, state_n;
    check_entry_t tbl [NUM_CHECKS];
    check_entry_t cur, nxt;
    logic [IDX_W-1:0] idx, idx_n, fail_idx_n;
    logic [IDX_W:0] n_lat, n_lat_n, n_clamp, cp_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [XLEN-1:0] flag_data, tgt_data, got_n;
    logic done_n, pass_n, fail_n, tmo_n, flag_hit, tgt_hit, last, tmo_hit, idle;

    assign cur = tbl[idx];
    assign nxt = tbl[idx + 1'b1];

    rf_shadow #(.XLEN(XLEN)) u_shadow (
        .clk(clk),
        .rst(rst),
        .wr_en(wb_en),
        .wr_addr(wb_addr),
        .wr_data(wb_data),
        .flag_addr(REG_IDX_W'(FLAG_REG)),
        .flag_data(flag_data),
        .tgt_addr(cur.rg),
        .tgt_data(tgt_data)
    );

    assign busy = state == WAIT || state == CHECK;
    assign idle = state == IDLE || state == DONE;
    assign n_clamp = n_checks > (IDX_W+1)'(NUM_CHECKS) ? (IDX_W+1)'(NUM_CHECKS) : n_checks;
    assign flag_hit = XLEN_MAX'(flag_data) == cur.flag;
    assign tgt_hit = XLEN_MAX'(tgt_data) == cur.exp;
    assign last = {1'b0, idx} == n_lat - 1'b1;
    assign tmo_hit = cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_n = state;
        idx_n = idx;
        n_lat_n = n_lat;
        cnt_n = cnt;
        done_n = done;
        pass_n = pass;
        fail_n = fail;
        tmo_n = timeout;
        fail_idx_n = fail_idx;
        got_n = fail_got;
        cp_n = checks_passed;
        if (idle && start) begin
            n_lat_n = n_clamp;
            idx_n = '0;
            cnt_n = '0;
            fail_n = 1'b0;
            tmo_n = 1'b0;
            cp_n = '0;
            done_n = n_clamp == '0;
            pass_n = n_clamp == '0;
            state_n = n_clamp == '0 ? DONE : WAIT;
        end else if (busy) begin
            cnt_n = cnt + 1'b1;
            cp_n = checks_passed + (IDX_W+1)'(state == CHECK && tgt_hit);
            // a result produced by CHECK this cycle outranks the watchdog
            if (state == CHECK && !tgt_hit) begin
                state_n = DONE;
                done_n = 1'b1;
                fail_n = 1'b1;
                fail_idx_n = idx;
                got_n = tgt_data;
            end else if (state == CHECK && last) begin
                state_n = DONE;
                done_n = 1'b1;
                pass_n = 1'b1;
            end else if (tmo_hit) begin
                state_n = DONE;
                done_n = 1'b1;
                fail_n = 1'b1;
                tmo_n = 1'b1;
                fail_idx_n = idx;
                got_n = flag_data;
            end else if (state == CHECK) begin
                idx_n = idx + 1'b1;
                state_n = nxt.flag == cur.flag ? CHECK : WAIT;
            end else if (flag_hit) begin
                state_n = CHECK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            n_lat <= '0;
            cnt <= '0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            timeout <= 1'b0;
            fail_idx <= '0;
            fail_got <= '0;
            checks_passed <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            n_lat <= n_lat_n;
            cnt <= cnt_n;
            done <= done_n;
            pass <= pass_n;
            fail <= fail_n;
            timeout <= tmo_n;
            fail_idx <= fail_idx_n;
            fail_got <= got_n;
            checks_passed <= cp_n;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_valid && idle && 32'(ld_idx) < NUM_CHECKS)
            tbl[ld_idx] <= '{flag: XLEN_MAX'(ld_flag), rg: ld_reg, exp: XLEN_MAX'(ld_exp)};
    end
endmodule

// File: tb/tb_rf_wb_checker.sv
// tb_rf_wb_checker: directed scoreboard bench for rf_wb_checker
module tb_rf_wb_checker;
    localparam int XLEN = 32;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_en = 1'b0;
    logic [4:0] wb_addr = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic ld_valid = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [XLEN-1:0] ld_flag = '0;
    logic [4:0] ld_reg = '0;
    logic [XLEN-1:0] ld_exp = '0;
    logic [IW:0] n_checks = '0;
    logic start = 1'b0;
    logic busy, done, pass, fail, timeout;
    logic [IW-1:0] fail_idx;
    logic [XLEN-1:0] fail_got;
    logic [IW:0] checks_passed;

    rf_wb_checker dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_flag(ld_flag), .ld_reg(ld_reg), .ld_exp(ld_exp),
        .n_checks(n_checks), .start(start), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_idx(fail_idx), .fail_got(fail_got), .checks_passed(checks_passed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pass, fail, tmo;
        logic [IW-1:0] idx;
        logic [XLEN-1:0] got;
        logic [IW:0] cp;
        int lat;
    } exp_t;

    exp_t q[$];
    exp_t em;
    int checks = 0, errors = 0, sc = 0, cyc = 0;
    logic done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic p, logic f, logic t, int i, int g, int c, int l);
        exp_t e;
        e.pass = p; e.fail = f; e.tmo = t;
        e.idx = IW'(i); e.got = XLEN'(g); e.cp = (IW+1)'(c); e.lat = l;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done pass %0b fail %0b", pass, fail);
            end else begin
                em = q.pop_front();
                chk("pass", 64'(pass), 64'(em.pass));
                chk("fail", 64'(fail), 64'(em.fail));
                chk("timeout", 64'(timeout), 64'(em.tmo));
                chk("busy_at_done", 64'(busy), 64'(0));
                chk("checks_passed", 64'(checks_passed), 64'(em.cp));
                if (em.fail) begin
                    chk("fail_idx", 64'(fail_idx), 64'(em.idx));
                    chk("fail_got", 64'(fail_got), 64'(em.got));
                end
                if (em.lat >= 0) chk("latency", 64'(cyc - sc), 64'(em.lat));
            end
        end
        done_q = done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(int a, int d);
        wb_en = 1'b1; wb_addr = 5'(a); wb_data = XLEN'(d);
        tick;
        wb_en = 1'b0;
        repeat (3) tick;
    endtask

    task automatic ld(int i, int f, int r, int x);
        ld_valid = 1'b1; ld_idx = IW'(i); ld_flag = XLEN'(f); ld_reg = 5'(r); ld_exp = XLEN'(x);
        tick;
        ld_valid = 1'b0;
    endtask

    task automatic go(int n, exp_t e);
        q.push_back(e);
        n_checks = (IW+1)'(n);
        start = 1'b1;
        tick;
        sc = cyc;
        start = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 400 && q.size() != 0; i++) tick;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d", q.size());
            q.delete();
        end
        tick;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_pass"}, 64'(pass), 64'(0));
        chk({tag, "_fail"}, 64'(fail), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout), 64'(0));
        chk({tag, "_fail_idx"}, 64'(fail_idx), 64'(0));
        chk({tag, "_fail_got"}, 64'(fail_got), 64'(0));
        chk({tag, "_checks_passed"}, 64'(checks_passed), 64'(0));
    endtask

    task automatic basic_stim(int x2);
        wb(1, 300);
        wb(20, 1);
        wb(1, 500);
        wb(2, x2);
        wb(20, 2);
    endtask

    initial begin
        repeat (2) tick;
        rst = 1'b0;
        check_zero("reset");

        ld(0, 1, 1, 300);
        ld(1, 2, 1, 500);
        ld(2, 2, 2, 100);
        go(3, mk(1, 0, 0, 0, 0, 3, -1));
        basic_stim(100);
        drain;

        go(3, mk(0, 1, 0, 2, 99, 2, -1));
        basic_stim(99);
        drain;

        go(3, mk(0, 1, 1, 0, 2, 0, 100));
        drain;

        ld(0, 7, 3, 0);
        go(1, mk(1, 0, 0, 0, 0, 1, 100));
        repeat (97) tick;
        wb(20, 7);
        drain;

        ld(0, 8, 3, 0);
        go(1, mk(0, 1, 1, 0, 8, 0, 100));
        repeat (98) tick;
        wb(20, 8);
        drain;

        wb(0, 5);
        ld(0, 0, 0, 0);
        wb(20, 0);
        go(1, mk(1, 0, 0, 0, 0, 1, -1));
        drain;

        ld(0, 9, 4, 0);
        go(1, mk(1, 0, 0, 0, 0, 1, -1));
        ld(0, 9, 4, 123);
        wb(20, 9);
        drain;

        ld(0, 1, 1, 300);
        ld(1, 2, 1, 500);
        ld(2, 2, 2, 100);
        n_checks = 4'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        chk("midrun_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_zero("midrun_reset");

        go(0, mk(1, 0, 0, 0, 0, 0, 0));
        drain;

        go(3, mk(1, 0, 0, 0, 0, 3, -1));
        basic_stim(100);
        drain;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
